// File: rtl/mul_seq_16b.sv
// -----------------------------------------------------------------------------
// mul_seq_16b
//   Multi-cycle unsigned 16x16 -> 32-bit shift-add multiplier. One rca_16b
//   instance is reused for 16 iterations, one partial-product add per cycle,
//   so the execute stage gets a multiply without a combinational array.
//
//   Ports:
//     clk    in   1   system clock, rising edge
//     rst    in   1   synchronous active-high reset
//     start  in   1   request a multiply (accepted only in IDLE or DONE)
//     A      in  16   multiplicand, unsigned, latched on accepted start
//     B      in  16   multiplier, unsigned, latched on accepted start
//     busy   out  1   high while iterating (RUN)
//     done   out  1   one-cycle pulse, P valid in that cycle
//     P      out 32   registered product, held until next completion/reset
//
// rca_16b
//   16-bit ripple-carry adder built from a chain of full-adder cells.
//
//   Ports:
//     A, B   in  16   addends
//     C_in   in   1   carry in
//     sum    out 16   sum
//     cout   out  1   carry out
// -----------------------------------------------------------------------------

module rca_16b (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        C_in,
  output logic [15:0] sum,
  output logic        cout
);

  logic [16:0] carry;

  assign carry[0] = C_in;

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_fa
      assign sum[gi]       = A[gi] ^ B[gi] ^ carry[gi];
      assign carry[gi + 1] = (A[gi] & B[gi]) | (carry[gi] & (A[gi] ^ B[gi]));
    end
  endgenerate

  assign cout = carry[16];

endmodule

module mul_seq_16b #(
  // Only 16 is supported: the adder instance is fixed at 16 bits.
  parameter int N     = 16,
  // Must be wide enough to hold the value N.
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N-1:0]     A,
  input  logic [N-1:0]     B,
  output logic             busy,
  output logic             done,
  output logic [2*N-1:0]   P
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_reg;
  logic [N-1:0]       mcand_reg;
  logic [N-1:0]       acc_hi_reg;
  logic [N-1:0]       acc_lo_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [2*N-1:0]     p_reg;

  logic [N-1:0]       addend;
  logic [N-1:0]       add_sum;
  logic               add_cout;
  logic [2*N-1:0]     acc_next;

  // Zero addend when the current multiplier bit is clear keeps the adder
  // inputs fully driven every cycle.
  assign addend = acc_lo_reg[0] ? mcand_reg : '0;

  rca_16b u_rca (
    .A    (acc_hi_reg),
    .B    (addend),
    .C_in (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Right shift of the 33-bit {cout, sum, acc_lo}: the carry becomes the new
  // MSB of acc_hi, and the LSB of sum moves into acc_lo as the multiplier
  // bit just consumed drops off the bottom.
  assign acc_next = {add_cout, add_sum, acc_lo_reg[N-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      mcand_reg  <= '0;
      acc_hi_reg <= '0;
      acc_lo_reg <= '0;
      cnt_reg    <= '0;
      p_reg      <= '0;
    end else begin
      case (state_reg)
        RUN: begin
          acc_hi_reg <= acc_next[2*N-1:N];
          acc_lo_reg <= acc_next[N-1:0];
          cnt_reg    <= cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(N - 1)) begin
            p_reg     <= acc_next;
            state_reg <= DONE;
          end
        end
        // IDLE and DONE accept a new operation identically, which gives
        // back-to-back issue straight out of DONE.
        default: begin
          if (start) begin
            mcand_reg  <= A;
            acc_lo_reg <= B;
            acc_hi_reg <= '0;
            cnt_reg    <= '0;
            state_reg  <= RUN;
          end else begin
            state_reg  <= IDLE;
          end
        end
      endcase
    end
  end

  // Moore outputs decoded from the state register only.
  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);
  assign P    = p_reg;

endmodule

// File: tb/tb_mul_seq_16b.sv
// -----------------------------------------------------------------------------
// tb_mul_seq_16b
//   Self-checking bench for mul_seq_16b. Expected products are pushed onto a
//   scoreboard queue when a start is driven and popped by a monitor at each
//   done pulse. Directed cases cover latency, carry-out, zero operands,
//   start-ignored-in-RUN, back-to-back issue and mid-RUN reset; a random
//   sweep follows.
// -----------------------------------------------------------------------------

module tb_mul_seq_16b;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        busy;
  logic        done;
  logic [31:0] P;

  int          n_checks;
  int          n_errors;
  int          done_cnt;
  bit          mon_en;
  logic [31:0] exp_q[$];

  mul_seq_16b #(.N(16), .CNT_W(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .P     (P)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Scoreboard monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (busy || done) check("busy_done_excl", 32'(busy & done), 32'd0);
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          check("P", P, e);
          $display("op done: P=%h expected=%h", P, e);
        end
      end
    end
  end

  // Called on a falling edge while the DUT is in IDLE or DONE; returns on the
  // falling edge after the accepting rising edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    A     = a;
    B     = b;
    start = 1'b1;
    exp_q.push_back(32'(a) * 32'(b));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts busy cycles until done is seen; returns on the negedge with done=1.
  task automatic wait_done(output int busy_cyc);
    bit ok;
    busy_cyc = 0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) busy_cyc++;
      @(negedge clk);
    end
    if (!ok) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int bc;
    int d0;
    logic [15:0] ra, rb;
    int gap;

    n_checks = 0;
    n_errors = 0;
    done_cnt = 0;
    mon_en   = 1'b0;
    rst      = 1'b1;
    start    = 1'b0;
    A        = '0;
    B        = '0;

    repeat (3) @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_P", P, 32'd0);
    @(negedge clk);

    // 1: basic latency and pulse width
    issue(16'd3, 16'd5);
    wait_done(bc);
    check("t1_busy_cycles", 32'(bc), 32'd16);
    check("t1_P", P, 32'h0000000F);
    @(negedge clk);
    check("t1_done_pulse", 32'(done), 32'd0);
    check("t1_P_hold", P, 32'h0000000F);

    // 2: carry-out on every iteration
    issue(16'hFFFF, 16'hFFFF);
    wait_done(bc);
    check("t2_P", P, 32'hFFFE0001);
    @(negedge clk);

    // 3: zero operands
    d0 = done_cnt;
    issue(16'h0000, 16'h1234);
    wait_done(bc);
    check("t3a_busy_cycles", 32'(bc), 32'd16);
    @(negedge clk);
    issue(16'h1234, 16'h0000);
    wait_done(bc);
    check("t3b_busy_cycles", 32'(bc), 32'd16);
    @(negedge clk);
    check("t3_done_count", 32'(done_cnt - d0), 32'd2);
    check("t3_P", P, 32'd0);

    // 4: start ignored in RUN, then back-to-back issue from DONE
    d0 = done_cnt;
    issue(16'h00FF, 16'h0100);
    repeat (4) @(negedge clk);
    A = 16'd7; B = 16'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(bc);
    check("t4a_P", P, 32'h0000FF00);
    issue(16'h8000, 16'h0002);
    check("t4_done_count", 32'(done_cnt - d0), 32'd1);
    check("t4_busy_b2b", 32'(busy), 32'd1);
    repeat (5) @(negedge clk);
    check("t4_P_hold_run", P, 32'h0000FF00);
    wait_done(bc);
    check("t4b_busy_cycles", 32'(bc), 32'd11);
    check("t4b_P", P, 32'h00010000);
    @(negedge clk);

    // 5: reset mid-RUN discards the operation
    issue(16'hABCD, 16'h1111);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_P", P, 32'd0);
    d0 = done_cnt;
    repeat (20) @(negedge clk);
    check("t5_no_done", 32'(done_cnt - d0), 32'd0);
    issue(16'd2, 16'd3);
    wait_done(bc);
    check("t5_P_fresh", P, 32'd6);
    @(negedge clk);

    // 6: random sweep with 0-3 idle cycles between starts
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 9))
        0:       ra = 16'hFFFF;
        1:       ra = 16'h0000;
        default: ra = 16'($urandom);
      endcase
      case ($urandom_range(0, 9))
        0:       rb = 16'hFFFF;
        1:       rb = 16'h0000;
        default: rb = 16'($urandom);
      endcase
      issue(ra, rb);
      wait_done(bc);
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
